// File: rtl/bankr_write_arbiter.sv
// bankr_write_arbiter
// Round-robin arbiter that shares the register bank's single write port between
// the ALU writeback (A) and the memory-load writeback (B). A winning request is
// captured in one registered output stage that drives Rw/Dir/DIn. Busy flags
// tell decode when a read address has a write waiting or in flight. Writes to
// register 0 are accepted but never reach the bank.
module bankr_write_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          A_valid,
    input  logic [AW-1:0] A_dir,
    input  logic [DW-1:0] A_data,
    output logic          A_ready,
    input  logic          B_valid,
    input  logic [AW-1:0] B_dir,
    input  logic [DW-1:0] B_data,
    output logic          B_ready,
    input  logic [AW-1:0] Rd1,
    input  logic [AW-1:0] Rd2,
    output logic          Busy1,
    output logic          Busy2,
    output logic          Rw,
    output logic [AW-1:0] Dir,
    output logic [DW-1:0] DIn,
    output logic [CW-1:0] WrCount
);

    // Which requester won the most recent transfer.
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_t;

    last_t         last_r;
    last_t         last_nxt_s;
    logic          grant_a_s;
    logic          grant_b_s;
    logic          a_ready_s;
    logic          b_ready_s;
    logic          xfer_s;
    logic [AW-1:0] xfer_dir_s;
    logic [DW-1:0] xfer_data_s;
    logic          rw_r;
    logic [AW-1:0] dir_r;
    logic [DW-1:0] din_r;
    logic [CW-1:0] wr_count_r;

    // A read address is busy when it is nonzero and matches the registered
    // write or any write currently being offered by a requester.
    function automatic logic addr_busy(
        input logic [AW-1:0] rd,
        input logic          rw,
        input logic [AW-1:0] dir,
        input logic          av,
        input logic [AW-1:0] ad,
        input logic          bv,
        input logic [AW-1:0] bd
    );
        logic hit;
        hit = (rw && (dir == rd)) || (av && (ad == rd)) || (bv && (bd == rd));
        return (rd != {AW{1'b0}}) && hit;
    endfunction

    // Round-robin grant: a lone requester always wins, contention goes to the
    // requester that did not win last time.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (A_valid && B_valid) begin
            if (last_r == LAST_B) begin
                grant_a_s = 1'b1;
            end else begin
                grant_b_s = 1'b1;
            end
        end else if (A_valid) begin
            grant_a_s = 1'b1;
        end else if (B_valid) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Nothing is accepted while reset is held, so requesters keep their data.
    assign a_ready_s   = A_valid && grant_a_s && !RST;
    assign b_ready_s   = B_valid && grant_b_s && !RST;
    assign xfer_s      = a_ready_s || b_ready_s;
    assign xfer_dir_s  = a_ready_s ? A_dir  : B_dir;
    assign xfer_data_s = a_ready_s ? A_data : B_data;

    // Next value of the round-robin pointer; it only moves on a transfer.
    always_comb begin
        last_nxt_s = last_r;
        if (a_ready_s) begin
            last_nxt_s = LAST_A;
        end else if (b_ready_s) begin
            last_nxt_s = LAST_B;
        end else begin
            last_nxt_s = last_r;
        end
    end

    // Round-robin pointer register; reset favours A on the first contention.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_r <= LAST_B;
        end else begin
            last_r <= last_nxt_s;
        end
    end

    // Output stage: capture the accepted write; register 0 is never enabled
    // and never counted. Dir/DIn hold when idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rw_r       <= 1'b0;
            dir_r      <= {AW{1'b0}};
            din_r      <= {DW{1'b0}};
            wr_count_r <= {CW{1'b0}};
        end else if (xfer_s) begin
            rw_r  <= (xfer_dir_s != {AW{1'b0}});
            dir_r <= xfer_dir_s;
            din_r <= xfer_data_s;
            if ((xfer_dir_s != {AW{1'b0}}) && (wr_count_r != {CW{1'b1}})) begin
                wr_count_r <= wr_count_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                wr_count_r <= wr_count_r;
            end
        end else begin
            rw_r       <= 1'b0;
            dir_r      <= dir_r;
            din_r      <= din_r;
            wr_count_r <= wr_count_r;
        end
    end

    assign A_ready = a_ready_s;
    assign B_ready = b_ready_s;
    assign Rw      = rw_r;
    assign Dir     = dir_r;
    assign DIn     = din_r;
    assign WrCount = wr_count_r;

    assign Busy1 = addr_busy(Rd1, rw_r, dir_r, A_valid, A_dir, B_valid, B_dir);
    assign Busy2 = addr_busy(Rd2, rw_r, dir_r, A_valid, A_dir, B_valid, B_dir);

endmodule

// File: tb/tb_bankr_write_arbiter.sv
// Self-checking bench for bankr_write_arbiter: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_bankr_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          A_valid, B_valid;
    logic [AW-1:0] A_dir, B_dir, Rd1, Rd2;
    logic [DW-1:0] A_data, B_data;
    logic          A_ready, B_ready, Busy1, Busy2, Rw;
    logic [AW-1:0] Dir;
    logic [DW-1:0] DIn;
    logic [CW-1:0] WrCount;

    logic          s_A_ready, s_B_ready, s_Busy1, s_Busy2, s_Rw;
    logic [AW-1:0] s_Dir;
    logic [DW-1:0] s_DIn;
    logic [1:0]    s_WrCount;

    int tests = 0;
    int fails = 0;

    // Model state
    int            m_last;   // 0 = A won last, 1 = B won last
    logic          m_rw;
    logic [AW-1:0] m_dir;
    logic [DW-1:0] m_din;
    int            m_cnt;
    int            m_scnt;

    always #5 CLK = ~CLK;

    bankr_write_arbiter #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .CLK(CLK), .RST(RST),
        .A_valid(A_valid), .A_dir(A_dir), .A_data(A_data), .A_ready(A_ready),
        .B_valid(B_valid), .B_dir(B_dir), .B_data(B_data), .B_ready(B_ready),
        .Rd1(Rd1), .Rd2(Rd2), .Busy1(Busy1), .Busy2(Busy2),
        .Rw(Rw), .Dir(Dir), .DIn(DIn), .WrCount(WrCount)
    );

    bankr_write_arbiter #(.DW(DW), .AW(AW), .CW(2)) dut_sat (
        .CLK(CLK), .RST(RST),
        .A_valid(A_valid), .A_dir(A_dir), .A_data(A_data), .A_ready(s_A_ready),
        .B_valid(B_valid), .B_dir(B_dir), .B_data(B_data), .B_ready(s_B_ready),
        .Rd1(Rd1), .Rd2(Rd2), .Busy1(s_Busy1), .Busy2(s_Busy2),
        .Rw(s_Rw), .Dir(s_Dir), .DIn(s_DIn), .WrCount(s_WrCount)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        A_valid = 1'b0; A_dir = 5'd0; A_data = 32'd0;
        B_valid = 1'b0; B_dir = 5'd0; B_data = 32'd0;
        Rd1 = 5'd0; Rd2 = 5'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    function automatic logic exp_busy(input logic [AW-1:0] rd);
        return (rd != 5'd0) && ((m_rw && m_dir == rd) || (A_valid && A_dir == rd)
                                || (B_valid && B_dir == rd));
    endfunction

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        A_valid = 1'b1; A_dir = 5'd3; A_data = 32'h0000_0033;
        tick();
        tests++;
        if (A_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_c1 got %b want 0", A_ready); end
        tick();
        tests++;
        if (A_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_c2 got %b want 0", A_ready); end
        tests++;
        if (Rw !== 1'b0) begin fails++; $display("FAIL reset_rw got %b want 0", Rw); end
        tests++;
        if (WrCount !== 16'd0) begin fails++; $display("FAIL reset_count got %0d want 0", WrCount); end
        tests++;
        if (Dir !== 5'd0 || DIn !== 32'd0) begin fails++; $display("FAIL reset_dir_din got %0d/%h want 0/0", Dir, DIn); end
        RST = 1'b0;
        #1;
        tests++;
        if (A_ready !== 1'b1) begin fails++; $display("FAIL reset_first_ready got %b want 1", A_ready); end
        tick();
        A_valid = 1'b0;
        tests++;
        if (Rw !== 1'b1 || Dir !== 5'd3) begin fails++; $display("FAIL reset_first_write got rw=%b dir=%0d want 1/3", Rw, Dir); end
        tick();
    endtask

    task automatic test_single_write();
        do_reset();
        A_valid = 1'b1; A_dir = 5'd5; A_data = 32'hDEADBEEF;
        #1;
        tests++;
        if (A_ready !== 1'b1 || B_ready !== 1'b0) begin fails++; $display("FAIL single_ready got A=%b B=%b want 1/0", A_ready, B_ready); end
        tick();
        A_valid = 1'b0;
        tests++;
        if (Rw !== 1'b1 || Dir !== 5'd5 || DIn !== 32'hDEADBEEF) begin
            fails++; $display("FAIL single_out got rw=%b dir=%0d din=%h want 1/5/deadbeef", Rw, Dir, DIn);
        end
        tests++;
        if (WrCount !== 16'd1) begin fails++; $display("FAIL single_count got %0d want 1", WrCount); end
        tick();
        tests++;
        if (Rw !== 1'b0 || Dir !== 5'd5 || DIn !== 32'hDEADBEEF) begin
            fails++; $display("FAIL single_idle got rw=%b dir=%0d din=%h want 0/5/deadbeef", Rw, Dir, DIn);
        end
    endtask

    task automatic test_contention();
        do_reset();
        A_valid = 1'b1; A_dir = 5'd1; A_data = 32'hAAAA_0001;
        B_valid = 1'b1; B_dir = 5'd2; B_data = 32'hBBBB_0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (A_ready !== (i % 2 == 0) || B_ready !== (i % 2 == 1)) begin
                fails++; $display("FAIL contention_grant[%0d] got A=%b B=%b", i, A_ready, B_ready);
            end
            tick();
            tests++;
            if (Rw !== 1'b1 || Dir !== ((i % 2 == 0) ? 5'd1 : 5'd2)) begin
                fails++; $display("FAIL contention_out[%0d] got rw=%b dir=%0d", i, Rw, Dir);
            end
        end
        A_valid = 1'b0; B_valid = 1'b0;
        tick();
        tests++;
        if (Rw !== 1'b0 || WrCount !== 16'd4) begin fails++; $display("FAIL contention_end got rw=%b cnt=%0d want 0/4", Rw, WrCount); end
    endtask

    task automatic test_reg0();
        do_reset();
        B_valid = 1'b1; B_dir = 5'd0; B_data = 32'd7; Rd1 = 5'd0;
        #1;
        tests++;
        if (B_ready !== 1'b1 || Busy1 !== 1'b0) begin fails++; $display("FAIL reg0_accept got ready=%b busy1=%b want 1/0", B_ready, Busy1); end
        tick();
        B_valid = 1'b0;
        #1;
        tests++;
        if (Rw !== 1'b0 || WrCount !== 16'd0 || Busy1 !== 1'b0) begin
            fails++; $display("FAIL reg0_out got rw=%b cnt=%0d busy1=%b want 0/0/0", Rw, WrCount, Busy1);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        Rd1 = 5'd9; Rd2 = 5'd3;
        B_valid = 1'b1; B_dir = 5'd9; B_data = 32'h0000_0099;
        #1;
        tests++;
        if (B_ready !== 1'b1 || Busy1 !== 1'b1 || Busy2 !== 1'b0) begin
            fails++; $display("FAIL hazard_c0 got ready=%b b1=%b b2=%b want 1/1/0", B_ready, Busy1, Busy2);
        end
        tick();
        B_valid = 1'b0;
        #1;
        tests++;
        if (Rw !== 1'b1 || Busy1 !== 1'b1 || Busy2 !== 1'b0) begin
            fails++; $display("FAIL hazard_c1 got rw=%b b1=%b b2=%b want 1/1/0", Rw, Busy1, Busy2);
        end
        tick();
        tests++;
        if (Busy1 !== 1'b0) begin fails++; $display("FAIL hazard_c2 got b1=%b want 0", Busy1); end
        Rd1 = 5'd0; Rd2 = 5'd0;
    endtask

    task automatic test_saturation();
        int exp_s;
        do_reset();
        A_valid = 1'b1; A_dir = 5'd4; A_data = 32'h4444_4444;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_s = (i + 1 > 3) ? 3 : i + 1;
            tests++;
            if (s_WrCount !== 2'(exp_s) || WrCount !== 16'(i + 1)) begin
                fails++; $display("FAIL saturation[%0d] got sat=%0d wide=%0d want %0d/%0d", i, s_WrCount, WrCount, exp_s, i + 1);
            end
        end
        A_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        A_valid = 1'b1; A_dir = 5'd6; A_data = 32'h6;
        B_valid = 1'b1; B_dir = 5'd7; B_data = 32'h7;
        tick();                      // A wins, write to 6 is registered
        RST = 1'b1;
        #1;
        tests++;
        if (A_ready !== 1'b0 || B_ready !== 1'b0) begin fails++; $display("FAIL midrst_ready got A=%b B=%b want 0/0", A_ready, B_ready); end
        tick();
        tests++;
        if (Rw !== 1'b0 || WrCount !== 16'd0) begin fails++; $display("FAIL midrst_drop got rw=%b cnt=%0d want 0/0", Rw, WrCount); end
        RST = 1'b0;
        #1;
        tests++;
        if (A_ready !== 1'b1 || B_ready !== 1'b0) begin fails++; $display("FAIL midrst_rearb got A=%b B=%b want 1/0", A_ready, B_ready); end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic a_hold, b_hold, ga, gb, eb1, eb2;
        logic [AW-1:0] d;
        do_reset();
        m_last = 1; m_rw = 1'b0; m_dir = 5'd0; m_din = 32'd0; m_cnt = 0; m_scnt = 0;
        a_hold = 1'b0; b_hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!a_hold) begin
                A_valid = ($urandom_range(0, 3) != 0);
                A_dir = 5'($urandom_range(0, 7));
                A_data = $urandom;
            end
            if (!b_hold) begin
                B_valid = ($urandom_range(0, 3) != 0);
                B_dir = 5'($urandom_range(0, 7));
                B_data = $urandom;
            end
            Rd1 = 5'($urandom_range(0, 7));
            Rd2 = 5'($urandom_range(0, 7));
            ga = A_valid && (!B_valid || m_last == 1);
            gb = B_valid && !ga;
            eb1 = exp_busy(Rd1);
            eb2 = exp_busy(Rd2);
            #1;
            tests++;
            if (A_ready !== ga || B_ready !== gb) begin
                fails++; $display("FAIL rand_grant[%0d] got A=%b B=%b want %b/%b", c, A_ready, B_ready, ga, gb);
            end
            tests++;
            if (Busy1 !== eb1 || Busy2 !== eb2) begin
                fails++; $display("FAIL rand_busy[%0d] got %b/%b want %b/%b", c, Busy1, Busy2, eb1, eb2);
            end
            a_hold = A_valid && !ga;
            b_hold = B_valid && !gb;
            tick();
            if (ga || gb) begin
                d = ga ? A_dir : B_dir;
                m_dir = d;
                m_din = ga ? A_data : B_data;
                m_rw = (d != 5'd0);
                if (m_rw && m_cnt < 65535) m_cnt++;
                if (m_rw && m_scnt < 3) m_scnt++;
                m_last = ga ? 0 : 1;
            end else begin
                m_rw = 1'b0;
            end
            tests++;
            if (Rw !== m_rw || Dir !== m_dir || DIn !== m_din) begin
                fails++; $display("FAIL rand_out[%0d] got rw=%b dir=%0d din=%h want %b/%0d/%h", c, Rw, Dir, DIn, m_rw, m_dir, m_din);
            end
            tests++;
            if (WrCount !== 16'(m_cnt) || s_WrCount !== 2'(m_scnt)) begin
                fails++; $display("FAIL rand_count[%0d] got %0d/%0d want %0d/%0d", c, WrCount, s_WrCount, m_cnt, m_scnt);
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_reg0();
        test_hazard();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
